// File: rtl/d_reg_stream_reader_pkg.sv
// -----------------------------------------------------------------------------
// d_reg_stream_reader_pkg
//   Shared online-division definitions used by the d-register writer and the
//   d-register stream reader: default word geometry, FSM state encoding and a
//   helper that decodes the final-word digit count.
// -----------------------------------------------------------------------------
package d_reg_stream_reader_pkg;

    // Digit slots per stored RAM word and RAM address width.
    localparam int unsigned UNROLLING_DFLT  = 64;
    localparam int unsigned ADDR_WIDTH_DFLT = 7;

    // Width of the final-word length field (0 encodes a full word).
    localparam int unsigned LAST_LEN_W = 7;

    // FSM encoding, kept as plain constants so legacy code can compare against it.
    typedef logic [2:0] state_t;

    localparam state_t StIdle  = 3'd0;
    localparam state_t StFetch = 3'd1;
    localparam state_t StWait  = 3'd2;
    localparam state_t StShift = 3'd3;
    localparam state_t StDone  = 3'd4;

    // Number of valid digits in the final word; a zero length means a full word.
    function automatic int unsigned final_word_digits(input logic [LAST_LEN_W-1:0] len,
                                                      input int unsigned           unrolling);
        if (len == '0) begin
            return unrolling;
        end
        return int'(len);
    endfunction

endpackage

// File: rtl/d_reg_stream_reader_if.sv
// -----------------------------------------------------------------------------
// d_reg_stream_reader_if
//   Bundles the RAM read port and the digit stream of the d-register reader.
//   master : the reader (drives rd_addr and the digit stream, takes RAM data
//            and dig_ready)
//   slave  : the environment (RAM model plus digit consumer)
//   Signals:
//     rd_addr               registered RAM read address
//     d_plus_rd/d_minus_rd  RAM read data, valid one cycle after rd_addr
//     dig_out               {plus,minus} bits of the current digit
//     dig_valid/dig_ready   stream handshake
//     dig_last              current digit is the final one of the job
// -----------------------------------------------------------------------------
interface d_reg_stream_reader_if
    import d_reg_stream_reader_pkg::*;
#(
    parameter int unsigned UNROLLING  = UNROLLING_DFLT,
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DFLT
) ();

    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [UNROLLING-1:0]  d_plus_rd;
    logic [UNROLLING-1:0]  d_minus_rd;
    logic [1:0]            dig_out;
    logic                  dig_valid;
    logic                  dig_ready;
    logic                  dig_last;

    modport master (
        output rd_addr,
        input  d_plus_rd,
        input  d_minus_rd,
        output dig_out,
        output dig_valid,
        input  dig_ready,
        output dig_last
    );

    modport slave (
        input  rd_addr,
        output d_plus_rd,
        output d_minus_rd,
        input  dig_out,
        input  dig_valid,
        output dig_ready,
        input  dig_last
    );

endinterface

// File: rtl/d_reg_stream_reader.sv
// -----------------------------------------------------------------------------
// d_reg_stream_reader
//   Reads a run of signed-digit words (plus/minus bit planes) from the
//   d-register RAM and streams them out one digit per transfer, oldest digit
//   (word MSB) first.
//   Ports:
//     clk         clock, rising edge
//     asyn_reset  asynchronous active-high reset
//     start       one-cycle job request (ignored while busy)
//     base_addr   first RAM word of the job            (sampled on start)
//     word_cnt    number of words to read, 0 = no-op   (sampled on start)
//     last_len    digits in the final word, 0 = full   (sampled on start)
//     busy        job in progress
//     done        one-cycle pulse after the final transfer
//     bus         RAM read port + digit stream (master side)
// -----------------------------------------------------------------------------
module d_reg_stream_reader
    import d_reg_stream_reader_pkg::*;
#(
    parameter int unsigned UNROLLING  = UNROLLING_DFLT,
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DFLT
) (
    input  logic                  clk,
    input  logic                  asyn_reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH-1:0] word_cnt,
    input  logic [LAST_LEN_W-1:0] last_len,
    output logic                  busy,
    output logic                  done,
    d_reg_stream_reader_if.master bus
);

    // Digit counter must hold the value UNROLLING itself.
    localparam int unsigned CNT_W = $clog2(UNROLLING + 1);

    state_t                state_q,      state_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q,    rd_addr_d;
    logic [ADDR_WIDTH-1:0] words_left_q, words_left_d;
    logic [CNT_W-1:0]      last_cnt_q,   last_cnt_d;
    logic [CNT_W-1:0]      cnt_q,        cnt_d;
    logic [UNROLLING-1:0]  plus_sr_q,    plus_sr_d;
    logic [UNROLLING-1:0]  minus_sr_q,   minus_sr_d;

    logic in_shift;
    logic final_word;
    logic xfer;

    assign in_shift   = (state_q == StShift);
    assign final_word = (words_left_q == ADDR_WIDTH'(1));
    assign xfer       = in_shift && bus.dig_ready;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        rd_addr_d    = rd_addr_q;
        words_left_d = words_left_q;
        last_cnt_d   = last_cnt_q;
        cnt_d        = cnt_q;
        plus_sr_d    = plus_sr_q;
        minus_sr_d   = minus_sr_q;

        case (state_q)
            StIdle: begin
                if (start) begin
                    if (word_cnt != '0) begin
                        rd_addr_d    = base_addr;
                        words_left_d = word_cnt;
                        last_cnt_d   = CNT_W'(final_word_digits(last_len, UNROLLING));
                        state_d      = StFetch;
                    end else begin
                        state_d = StDone;
                    end
                end
            end

            // Address is already registered; the RAM answers during StWait.
            StFetch: begin
                state_d = StWait;
            end

            StWait: begin
                plus_sr_d  = bus.d_plus_rd;
                minus_sr_d = bus.d_minus_rd;
                cnt_d      = final_word ? last_cnt_q : CNT_W'(UNROLLING);
                state_d    = StShift;
            end

            StShift: begin
                if (xfer) begin
                    plus_sr_d  = {plus_sr_q[UNROLLING-2:0], 1'b0};
                    minus_sr_d = {minus_sr_q[UNROLLING-2:0], 1'b0};
                    cnt_d      = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        if (final_word) begin
                            state_d = StDone;
                        end else begin
                            // Address wraps naturally at 2^ADDR_WIDTH.
                            rd_addr_d    = rd_addr_q + ADDR_WIDTH'(1);
                            words_left_d = words_left_q - ADDR_WIDTH'(1);
                            state_d      = StFetch;
                        end
                    end
                end
            end

            StDone: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge asyn_reset) begin
        if (asyn_reset) begin
            state_q      <= StIdle;
            rd_addr_q    <= '0;
            words_left_q <= '0;
            last_cnt_q   <= '0;
            cnt_q        <= '0;
            plus_sr_q    <= '0;
            minus_sr_q   <= '0;
        end else begin
            state_q      <= state_d;
            rd_addr_q    <= rd_addr_d;
            words_left_q <= words_left_d;
            last_cnt_q   <= last_cnt_d;
            cnt_q        <= cnt_d;
            plus_sr_q    <= plus_sr_d;
            minus_sr_q   <= minus_sr_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs (decoded from registered state only)
    // -------------------------------------------------------------------------
    assign bus.rd_addr   = rd_addr_q;
    assign bus.dig_valid = in_shift;
    // Gated so stale shift-register contents never appear outside StShift.
    assign bus.dig_out   = in_shift ? {plus_sr_q[UNROLLING-1], minus_sr_q[UNROLLING-1]} : 2'b00;
    assign bus.dig_last  = in_shift && final_word && (cnt_q == CNT_W'(1));
    assign busy          = (state_q != StIdle);
    assign done          = (state_q == StDone);

endmodule

// File: tb/tb_d_reg_stream_reader.sv
// -----------------------------------------------------------------------------
// tb_d_reg_stream_reader
//   Self-checking bench for d_reg_stream_reader. A registered RAM model feeds
//   the reader; a monitor logs every digit transfer and done pulse relative to
//   the start edge (start cycle = 0). Expected digits are built from the RAM
//   contents when a job is launched and compared against the log.
// -----------------------------------------------------------------------------
module tb_d_reg_stream_reader;

    localparam int UNR = 64;
    localparam int AW  = 7;

    logic          clk = 1'b0;
    logic          asyn_reset;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW-1:0] word_cnt;
    logic [6:0]    last_len;
    logic          busy;
    logic          done;

    d_reg_stream_reader_if #(.UNROLLING(UNR), .ADDR_WIDTH(AW)) bus_if ();

    d_reg_stream_reader #(.UNROLLING(UNR), .ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .asyn_reset (asyn_reset),
        .start      (start),
        .base_addr  (base_addr),
        .word_cnt   (word_cnt),
        .last_len   (last_len),
        .busy       (busy),
        .done       (done),
        .bus        (bus_if)
    );

    always #5 clk = ~clk;

    // Registered-read RAM: data valid one cycle after the address.
    logic [UNR-1:0] mem_plus  [0:127];
    logic [UNR-1:0] mem_minus [0:127];

    always @(posedge clk) begin
        bus_if.d_plus_rd  <= mem_plus[bus_if.rd_addr];
        bus_if.d_minus_rd <= mem_minus[bus_if.rd_addr];
    end

    typedef struct {
        int            rel;
        logic [1:0]    dig;
        logic          last;
        logic [AW-1:0] addr;
    } ev_t;

    ev_t exp_q[$];
    ev_t obs_q[$];
    int  done_q[$];
    int  busy_cnt;
    int  valid_cnt;
    int  cyc = 0;
    int  start_cyc = 0;
    int  checks = 0;
    int  errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: logs transfers and done pulses with their cycle index.
    always @(negedge clk) begin
        ev_t e;
        if (!asyn_reset) begin
            if (bus_if.dig_valid && bus_if.dig_ready) begin
                e.rel  = cyc - start_cyc + 1;
                e.dig  = bus_if.dig_out;
                e.last = bus_if.dig_last;
                e.addr = bus_if.rd_addr;
                obs_q.push_back(e);
            end
            if (done) done_q.push_back(cyc - start_cyc + 1);
            if (busy) busy_cnt++;
            if (bus_if.dig_valid) valid_cnt++;
        end
    end

    // Builds the expected digit stream assuming dig_ready stays high.
    task automatic push_expected(input int base, input int cnt, input int len,
                                 output int exp_done);
        int   n_last;
        int   n;
        ev_t  e;
        logic [AW-1:0] a;
        n_last = (len == 0) ? 64 : len;
        exp_q.delete();
        for (int w = 0; w < cnt; w++) begin
            a = AW'(base + w);
            n = (w == cnt - 1) ? n_last : 64;
            for (int i = 0; i < n; i++) begin
                e.rel  = 3 + w * 66 + i;
                e.dig  = {mem_plus[a][63-i], mem_minus[a][63-i]};
                e.last = (w == cnt - 1) && (i == n - 1);
                e.addr = a;
                exp_q.push_back(e);
            end
        end
        exp_done = 3 + (cnt - 1) * 66 + n_last;
    endtask

    // Pulses start; returns #1 after the start edge (cycle 1).
    task automatic start_job(input int base, input int cnt, input int len);
        @(negedge clk);
        base_addr = AW'(base);
        word_cnt  = AW'(cnt);
        last_len  = 7'(len);
        start     = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        start_cyc = cyc;
        obs_q.delete();
        done_q.delete();
        busy_cnt  = 0;
        valid_cnt = 0;
    endtask

    task automatic wait_done(input int budget, output bit timed_out);
        timed_out = 1'b1;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            #1;
            if (done_q.size() > 0) begin
                timed_out = 1'b0;
                break;
            end
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        asyn_reset       = 1'b1;
        start            = 1'b0;
        base_addr        = '0;
        word_cnt         = '0;
        last_len         = '0;
        bus_if.dig_ready = 1'b1;
        #12;
        checks++; if (bus_if.rd_addr !== 7'd0) begin errors++; $display("FAIL reset_rd_addr: got %0d expected 0", bus_if.rd_addr); end
        checks++; if (bus_if.dig_out !== 2'b00) begin errors++; $display("FAIL reset_dig_out: got %b expected 00", bus_if.dig_out); end
        checks++; if (bus_if.dig_valid !== 1'b0) begin errors++; $display("FAIL reset_dig_valid: got %b expected 0", bus_if.dig_valid); end
        checks++; if (bus_if.dig_last !== 1'b0) begin errors++; $display("FAIL reset_dig_last: got %b expected 0", bus_if.dig_last); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        @(negedge clk);
        asyn_reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_word();
        int  exp_done;
        bit  to;
        ev_t e, o;
        mem_plus[5]  = 64'hA000_0000_0000_0000;
        mem_minus[5] = 64'h0;
        push_expected(5, 1, 3, exp_done);
        start_job(5, 1, 3);
        checks++; if (bus_if.rd_addr !== 7'd5) begin errors++; $display("FAIL single_rd_addr: got %0d expected 5", bus_if.rd_addr); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b expected 1", busy); end
        wait_done(20, to);
        checks++; if (to || done_q.size() != 1 || done_q[0] != exp_done) begin
            errors++; $display("FAIL single_done: got %0d pulses (first at %0d) expected 1 at %0d",
                                done_q.size(), (done_q.size() > 0) ? done_q[0] : -1, exp_done);
        end
        checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL single_count: got %0d digits expected %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o.dig !== e.dig || o.last !== e.last || o.rel !== e.rel || o.addr !== e.addr) begin
                errors++;
                $display("FAIL single_digit: got dig=%b last=%b cyc=%0d addr=%0d expected dig=%b last=%b cyc=%0d addr=%0d",
                         o.dig, o.last, o.rel, o.addr, e.dig, e.last, e.rel, e.addr);
            end
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle: busy got %b expected 0", busy); end
    endtask

    task automatic test_wrap();
        int  exp_done;
        bit  to;
        ev_t e, o;
        push_expected(127, 2, 0, exp_done);
        start_job(127, 2, 0);
        wait_done(300, to);
        checks++; if (to || done_q.size() != 1 || done_q[0] != exp_done) begin
            errors++; $display("FAIL wrap_done: got %0d pulses (first at %0d) expected 1 at %0d",
                                done_q.size(), (done_q.size() > 0) ? done_q[0] : -1, exp_done);
        end
        checks++; if (obs_q.size() != 128) begin errors++; $display("FAIL wrap_count: got %0d digits expected 128", obs_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o.dig !== e.dig || o.last !== e.last || o.rel !== e.rel || o.addr !== e.addr) begin
                errors++;
                $display("FAIL wrap_digit: got dig=%b last=%b cyc=%0d addr=%0d expected dig=%b last=%b cyc=%0d addr=%0d",
                         o.dig, o.last, o.rel, o.addr, e.dig, e.last, e.rel, e.addr);
            end
        end
    endtask

    task automatic test_backpressure();
        int         exp_done;
        bit         to;
        bit         stall;
        logic [1:0] prev_dig;
        logic       prev_last;
        ev_t        e, o;
        push_expected(40, 1, 0, exp_done);
        start_job(40, 1, 0);
        to    = 1'b1;
        stall = 1'b0;
        for (int k = 0; k < 600; k++) begin
            @(posedge clk);
            #1;
            if (stall) begin
                checks++;
                if (bus_if.dig_valid !== 1'b1 || bus_if.dig_out !== prev_dig || bus_if.dig_last !== prev_last) begin
                    errors++;
                    $display("FAIL bp_hold: got valid=%b dig=%b last=%b expected valid=1 dig=%b last=%b",
                             bus_if.dig_valid, bus_if.dig_out, bus_if.dig_last, prev_dig, prev_last);
                end
            end
            if (done_q.size() > 0) begin
                to = 1'b0;
                break;
            end
            prev_dig         = bus_if.dig_out;
            prev_last        = bus_if.dig_last;
            bus_if.dig_ready = 1'($urandom_range(0, 1));
            stall            = bus_if.dig_valid && !bus_if.dig_ready;
        end
        bus_if.dig_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (to || done_q.size() != 1) begin errors++; $display("FAIL bp_done: got %0d pulses expected 1", done_q.size()); end
        checks++; if (obs_q.size() != 64) begin errors++; $display("FAIL bp_count: got %0d digits expected 64", obs_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o.dig !== e.dig || o.last !== e.last) begin
                errors++;
                $display("FAIL bp_digit: got dig=%b last=%b expected dig=%b last=%b", o.dig, o.last, e.dig, e.last);
            end
        end
    endtask

    task automatic test_start_ignored();
        int  exp_done;
        bit  to;
        ev_t e, o;
        push_expected(10, 1, 20, exp_done);
        start_job(10, 1, 20);
        repeat (5) @(negedge clk);
        base_addr = 7'd50;
        word_cnt  = 7'd3;
        last_len  = 7'd5;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(60, to);
        repeat (10) @(negedge clk);
        checks++; if (to || done_q.size() != 1 || done_q[0] != exp_done) begin
            errors++; $display("FAIL ign_done: got %0d pulses (first at %0d) expected 1 at %0d",
                                done_q.size(), (done_q.size() > 0) ? done_q[0] : -1, exp_done);
        end
        checks++; if (obs_q.size() != 20) begin errors++; $display("FAIL ign_count: got %0d digits expected 20", obs_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o.dig !== e.dig || o.last !== e.last || o.rel !== e.rel || o.addr !== e.addr) begin
                errors++;
                $display("FAIL ign_digit: got dig=%b last=%b cyc=%0d addr=%0d expected dig=%b last=%b cyc=%0d addr=%0d",
                         o.dig, o.last, o.rel, o.addr, e.dig, e.last, e.rel, e.addr);
            end
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ign_idle: busy got %b expected 0", busy); end
    endtask

    task automatic test_zero_words();
        start_job(3, 0, 5);
        repeat (5) @(negedge clk);
        checks++; if (done_q.size() != 1 || done_q[0] != 1) begin
            errors++; $display("FAIL zero_done: got %0d pulses (first at %0d) expected 1 at 1",
                                done_q.size(), (done_q.size() > 0) ? done_q[0] : -1);
        end
        checks++; if (busy_cnt != 1) begin errors++; $display("FAIL zero_busy: got %0d cycles expected 1", busy_cnt); end
        checks++; if (valid_cnt != 0) begin errors++; $display("FAIL zero_valid: got %0d cycles expected 0", valid_cnt); end
    endtask

    task automatic test_reset_mid_job();
        int exp_done;
        bit reached;
        push_expected(20, 1, 0, exp_done);
        start_job(20, 1, 0);
        reached = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (obs_q.size() >= 2) begin
                reached = 1'b1;
                break;
            end
        end
        checks++; if (!reached) begin errors++; $display("FAIL rst_reach: got %0d digits expected >= 2", obs_q.size()); end
        #1;
        asyn_reset = 1'b1;
        #1;
        checks++;
        if (bus_if.rd_addr !== 7'd0 || bus_if.dig_out !== 2'b00 || bus_if.dig_valid !== 1'b0 ||
            bus_if.dig_last !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL rst_outputs: got addr=%0d dig=%b valid=%b last=%b busy=%b done=%b expected all 0",
                     bus_if.rd_addr, bus_if.dig_out, bus_if.dig_valid, bus_if.dig_last, busy, done);
        end
        repeat (2) @(negedge clk);
        asyn_reset = 1'b0;
        repeat (5) @(negedge clk);
        checks++; if (done_q.size() != 0) begin errors++; $display("FAIL rst_no_done: got %0d pulses expected 0", done_q.size()); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_idle: busy got %b expected 0", busy); end
        test_single_word();
    endtask

    initial begin
        for (int i = 0; i < 128; i++) begin
            mem_plus[i]  = {$urandom, $urandom};
            mem_minus[i] = {$urandom, $urandom};
        end
        // Include {1,1} digits to confirm they pass through unmodified.
        mem_plus[10]  = 64'hF0F0_0000_1234_5678;
        mem_minus[10] = 64'hFF00_0000_8765_4321;
        test_reset();
        test_single_word();
        test_wrap();
        test_backpressure();
        test_start_ignored();
        test_zero_words();
        test_reset_mid_job();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule

// File: doc/d_reg_stream_reader.md
D_REG_STREAM_READER -- requirements
Module: d_reg_stream_reader

Interface
REQ-001 Parameter UNROLLING, default 64, meaning digit slots per stored RAM word.
REQ-002 Parameter ADDR_WIDTH, default 7, meaning RAM address width.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 asyn_reset  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  one-cycle pulse; begins a read-out job.
REQ-006 base_addr  input  ADDR_WIDTH  first RAM word of the job; sampled on start.
REQ-007 word_cnt  input  ADDR_WIDTH  number of words to read; sampled on start.
REQ-008 last_len  input  7  valid digits in the final word, 1..64 (0 means 64); sampled on start.
REQ-009 rd_addr  output  ADDR_WIDTH  registered RAM read address.
REQ-010 d_plus_rd, d_minus_rd  input  UNROLLING  RAM read data, valid one cycle after rd_addr.
REQ-011 dig_out  output  2  {plus,minus} signed-digit bits of the current digit.
REQ-012 dig_valid  output  1  dig_out holds a digit.
REQ-013 dig_ready  input  1  consumer accepts; a transfer occurs when dig_valid && dig_ready.
REQ-014 dig_last  output  1  current digit is the final digit of the job.
REQ-015 busy  output  1  job in progress (state not IDLE).
REQ-016 done  output  1  one-cycle pulse after the final transfer.

Function
REQ-017 FSM states SHALL be IDLE, FETCH, WAIT, SHIFT, DONE.
REQ-018 IDLE: on start with word_cnt != 0, latch inputs, set rd_addr=base_addr, go to FETCH; with word_cnt == 0, go directly to DONE.
REQ-019 FETCH: RAM address presented; go to WAIT next cycle.
REQ-020 WAIT: at cycle end, load d_plus_rd/d_minus_rd into internal shift registers and set the digit count to UNROLLING, or to last_len on the final word; go to SHIFT.
REQ-021 SHIFT: dig_valid=1; dig_out={plus_sr[UNROLLING-1], minus_sr[UNROLLING-1]}; word bit 63 is the oldest digit and is emitted first.
REQ-022 On each transfer, both shift registers shift left by one with zero fill, and the digit count decrements.
REQ-023 After the last digit of a non-final word transfers, rd_addr increments and the FSM goes to FETCH.
REQ-024 After the last digit of the final word transfers, the FSM goes to DONE.
REQ-025 DONE: done=1 for exactly one cycle; go to IDLE.
REQ-026 dig_ready low in SHIFT SHALL hold dig_out, dig_valid, dig_last, and all state stable.
REQ-027 dig_last=1 only in SHIFT, on the final word, when the digit count == 1.
REQ-028 Latency: first dig_valid SHALL occur 3 cycles after the start edge; each word boundary inserts 2 idle cycles (FETCH, WAIT).
REQ-029 rd_addr increment SHALL wrap modulo 2^ADDR_WIDTH.
REQ-030 start while busy SHALL be ignored, and latched job parameters SHALL be unchanged.
REQ-031 Digit {1,1} SHALL be passed through unmodified.
REQ-032 dig_valid SHALL be 0 in every state except SHIFT.

Reset
REQ-033 asyn_reset SHALL force IDLE; rd_addr, dig_out, dig_valid, dig_last, busy, done, shift registers, and counters all 0.
REQ-034 Reset mid-job SHALL abort the job with no done pulse; the next start runs normally.

Structure
REQ-035 UNROLLING, ADDR_WIDTH, and the FSM state encoding SHALL live in the shared online-division package used by the d-register writer.
REQ-036 Single module; no sub-module, except an optional dual shift-register slice named d_digit_shifter.

Verification
REQ-037 Reset, then start with base=5, word_cnt=1, last_len=3, plus word=0xA000..0, minus=0, ready=1 -> rd_addr=5; digits 10,00,10 on cycles 3-5; dig_last on the 3rd; done on cycle 6.
REQ-038 word_cnt=2, base=127, last_len=0 -> rd_addr 127 then 0 (wrap); 128 digits total; 2-cycle gap between words; done once.
REQ-039 dig_ready toggled pseudo-randomly on a 1-word, 64-digit job -> digit sequence identical to the ready=1 run; no drops or duplicates.
REQ-040 start pulsed again mid-SHIFT with different base_addr -> ignored; original job completes unchanged.
REQ-041 word_cnt=0 -> no dig_valid; done one cycle after start; busy high for exactly 1 cycle.
REQ-042 asyn_reset asserted mid-SHIFT -> all outputs 0 immediately, no done pulse; subsequent start behaves as in REQ-037.
